cmd_tl_bridge: RTL

Byte-stream command bridge acting as TileLink-UL master. It pops command bytes from a command FIFO, assembles 64-bit Get/PutFullData requests, and drives them onto the shared `tilelink` bus that feeds `rom` and other slaves. It serializes the D-channel result back as bytes into a response FIFO. It is the host/debug-side entry point upstream of the memory-mapped slaves.

---
 rtl/cmd_bridge_pkg.sv | 22 ++
 rtl/tl_pkg.sv | 11 +
 rtl/cmd_tl_bridge.sv | 174 +++++++++++++++++
 3 files changed

// File: rtl/cmd_bridge_pkg.sv
// Command bytes, status codes and FSM states for the byte-stream to TileLink bridge.
package cmd_bridge_pkg;

  localparam logic [7:0] CMD_RD = 8'h01;
  localparam logic [7:0] CMD_WR = 8'h02;

  localparam logic [7:0] ST_OK       = 8'h00;
  localparam logic [7:0] ST_DENIED   = 8'h01;
  localparam logic [7:0] ST_MISALIGN = 8'h02;
  localparam logic [7:0] ST_BADCMD   = 8'hFF;

  typedef enum logic [2:0] {
    S_IDLE,
    S_ADDR,
    S_DATA,
    S_REQ,
    S_RESP,
    S_STATUS,
    S_RDATA
  } state_t;

endpackage

// File: rtl/tl_pkg.sv
// TileLink-UL opcode encodings shared by the bus masters and slaves (rom, bridge).
package tl_pkg;

  localparam logic [2:0] GET      = 3'd4;
  localparam logic [2:0] PUT_FULL = 3'd0;
  localparam logic [2:0] ACK      = 3'd0;
  localparam logic [2:0] ACK_DATA = 3'd1;

  localparam int SRC_W = 4;

endpackage

// File: rtl/cmd_tl_bridge.sv
// Pops opcode/address/data bytes, issues one 64-bit TileLink-UL Get or PutFullData,
// and pushes a status byte (plus 8 read bytes on a good read) into the response FIFO.
module cmd_tl_bridge
  import tl_pkg::*;
  import cmd_bridge_pkg::*;
#(
  parameter int ADDR_W = 64,
  parameter int DATA_W = 64
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                cmd_empty,
  input  logic [7:0]          cmd_dout,
  output logic                cmd_rd_en,
  input  logic                res_full,
  output logic                res_wr_en,
  output logic [7:0]          res_din,
  output logic                a_valid,
  input  logic                a_ready,
  output logic [2:0]          a_opcode,
  output logic [2:0]          a_size,
  output logic [SRC_W-1:0]    a_source,
  output logic [ADDR_W-1:0]   a_address,
  output logic [DATA_W/8-1:0] a_mask,
  output logic [DATA_W-1:0]   a_data,
  output logic                d_ready,
  input  logic                d_valid,
  input  logic [2:0]          d_opcode,
  input  logic                d_denied,
  input  logic                d_corrupt,
  input  logic [DATA_W-1:0]   d_data
);

  state_t state_reg, state_next;
  logic [2:0] cnt_reg, cnt_next;

  logic              is_wr;
  logic [ADDR_W-1:0] addr_sr;
  logic [DATA_W-1:0] data_sr;
  logic [DATA_W-1:0] rdata;
  logic [7:0]        status;

  logic       cmd_latch, addr_shift, data_shift, launch, status_load, push;
  logic [7:0] status_val, push_byte;

  // Address and write data are presented straight from the assembly registers;
  // they cannot change while a_valid is high because no bytes are popped then.
  assign a_address = addr_sr;
  assign a_data    = data_sr;
  assign a_source  = '0;

  always_comb begin
    state_next  = state_reg;
    cnt_next    = cnt_reg;
    cmd_rd_en   = 1'b0;
    d_ready     = 1'b0;
    cmd_latch   = 1'b0;
    addr_shift  = 1'b0;
    data_shift  = 1'b0;
    launch      = 1'b0;
    status_load = 1'b0;
    status_val  = ST_OK;
    push        = 1'b0;
    push_byte   = status;
    case (state_reg)
      S_IDLE: begin
        cmd_rd_en = !cmd_empty;
        if (!cmd_empty) begin
          if (cmd_dout == CMD_RD || cmd_dout == CMD_WR) begin
            cmd_latch  = 1'b1;
            cnt_next   = 3'd0;
            state_next = S_ADDR;
          end else begin
            status_load = 1'b1;
            status_val  = ST_BADCMD;
            state_next  = S_STATUS;
          end
        end
      end
      S_ADDR, S_DATA: begin
        cmd_rd_en = !cmd_empty;
        if (!cmd_empty) begin
          addr_shift = (state_reg == S_ADDR);
          data_shift = (state_reg == S_DATA);
          cnt_next   = cnt_reg + 3'd1;
          if (cnt_reg == 3'd7) begin
            // A write still drains its data bytes before a misalignment is reported.
            if (state_reg == S_ADDR && is_wr) begin
              state_next = S_DATA;
            end else if (addr_sr[2:0] != 3'd0) begin
              status_load = 1'b1;
              status_val  = ST_MISALIGN;
              state_next  = S_STATUS;
            end else begin
              launch     = 1'b1;
              state_next = S_REQ;
            end
          end
        end
      end
      S_REQ: begin
        if (a_valid && a_ready) state_next = S_RESP;
      end
      S_RESP: begin
        d_ready = 1'b1;
        if (d_valid) begin
          status_load = 1'b1;
          status_val  = (d_denied || d_corrupt) ? ST_DENIED : ST_OK;
          state_next  = S_STATUS;
        end
      end
      S_STATUS: begin
        if (!res_full) begin
          push       = 1'b1;
          push_byte  = status;
          cnt_next   = 3'd0;
          state_next = (!is_wr && status == ST_OK) ? S_RDATA : S_IDLE;
        end
      end
      S_RDATA: begin
        if (!res_full) begin
          push      = 1'b1;
          push_byte = rdata[{cnt_reg, 3'b000} +: 8];
          cnt_next  = cnt_reg + 3'd1;
          if (cnt_reg == 3'd7) state_next = S_IDLE;
        end
      end
      default: state_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg <= S_IDLE;
      cnt_reg   <= 3'd0;
    end else begin
      state_reg <= state_next;
      cnt_reg   <= cnt_next;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      is_wr     <= 1'b0;
      addr_sr   <= '0;
      data_sr   <= '0;
      rdata     <= '0;
      status    <= 8'h00;
      res_wr_en <= 1'b0;
      res_din   <= 8'h00;
      a_valid   <= 1'b0;
      a_opcode  <= 3'd0;
      a_size    <= 3'd0;
      a_mask    <= '0;
    end else begin
      res_wr_en <= push;
      if (push)        res_din <= push_byte;
      if (cmd_latch)   is_wr <= (cmd_dout == CMD_WR);
      if (addr_shift)  addr_sr[{cnt_reg, 3'b000} +: 8] <= cmd_dout;
      if (data_shift)  data_sr[{cnt_reg, 3'b000} +: 8] <= cmd_dout;
      if (status_load) status <= status_val;
      if (state_reg == S_RESP && d_valid && d_opcode == ACK_DATA) rdata <= d_data;
      if (launch) begin
        a_valid  <= 1'b1;
        a_opcode <= is_wr ? PUT_FULL : GET;
        a_size   <= 3'd3;
        a_mask   <= '1;
      end else if (a_valid && a_ready) begin
        a_valid <= 1'b0;
      end
    end
  end

endmodule
